// File: rtl/parallel_to_serial_pkg.sv
// Shared types and sizing helpers for the parallel_to_serial serializer.
// PARALLEL_TO_SERIAL_PARITY_EN adds one even-parity beat per word.
package parallel_to_serial_pkg;

  typedef enum logic {IDLE = 1'b0, SHIFT = 1'b1} p2s_state_t;

`ifdef PARALLEL_TO_SERIAL_PARITY_EN
  localparam int par_beats = 1;
`else
  localparam int par_beats = 0;
`endif

  function automatic int cnt_w(input int width);
    return $clog2(width + 1);
  endfunction

  function automatic int beats_per_word(input int width);
    return width + par_beats;
  endfunction

endpackage

// File: rtl/p2s_hold_buf.sv
// Single-entry holding buffer; ready is derived only from the full flag.
module p2s_hold_buf #(
  parameter int width = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [width-1:0] push_data,
  input  logic             pop,
  output logic [width-1:0] data,
  output logic             full,
  output logic             ready
);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      data <= '0;
      full <= 1'b0;
    end else if (push) begin
      data <= push_data;
      full <= 1'b1;
    end else if (pop) begin
      full <= 1'b0;
    end
  end

  assign ready = !full;

endmodule

// File: rtl/parallel_to_serial.sv
// Word-to-bit serializer, LSB first, with a one-word holding buffer for gapless streaming.
// Define PARALLEL_TO_SERIAL_PARITY_EN to append an even-parity beat after each word.
module parallel_to_serial
  import parallel_to_serial_pkg::*;
#(
  parameter int width = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             parallel_valid,
  output logic             parallel_ready,
  input  logic [width-1:0] parallel_data,
  output logic             serial_valid,
  output logic             serial_data,
  input  logic             serial_ready,
  output logic             busy
);

  localparam int CW = cnt_w(width);
  localparam logic [CW-1:0] LAST = CW'(beats_per_word(width) - 1);

  p2s_state_t       state_q, state_d;
  logic [width-1:0] sh, hold_data;
  logic [CW-1:0]    cnt;
  logic             hold_full, fill;
  logic             accept, advance, last;
  logic             pop, load_direct, push_hold, go_idle;

  assign accept  = parallel_valid && parallel_ready;
  assign advance = (state_q == SHIFT) && serial_ready;
  assign last    = advance && (cnt == LAST);

  always_comb begin
    state_d     = state_q;
    pop         = 1'b0;
    load_direct = 1'b0;
    push_hold   = 1'b0;
    go_idle     = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          load_direct = 1'b1;
          state_d     = SHIFT;
        end
      end
      SHIFT: begin
        // accept cannot coincide with pop: parallel_ready is low while hold is full
        if (last) begin
          if (hold_full)   pop = 1'b1;
          else if (accept) load_direct = 1'b1;
          else begin
            go_idle = 1'b1;
            state_d = IDLE;
          end
        end else if (accept) begin
          push_hold = 1'b1;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      sh      <= '0;
      cnt     <= '0;
    end else begin
      state_q <= state_d;
      if (pop) begin
        sh  <= hold_data;
        cnt <= '0;
      end else if (load_direct) begin
        sh  <= parallel_data;
        cnt <= '0;
      end else if (go_idle) begin
        sh  <= '0;
        cnt <= '0;
      end else if (advance) begin
        // fill from the top so the parity bit lands in sh[0] after the data bits
        sh  <= {fill, sh[width-1:1]};
        cnt <= cnt + CW'(1);
      end
    end
  end

`ifdef PARALLEL_TO_SERIAL_PARITY_EN
  logic par_q;
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)             par_q <= 1'b0;
    else if (pop)         par_q <= ^hold_data;
    else if (load_direct) par_q <= ^parallel_data;
  end
  assign fill = par_q;
`else
  assign fill = 1'b0;
`endif

  p2s_hold_buf #(.width(width)) u_hold (
    .clk       (clk),
    .rst       (rst),
    .push      (push_hold),
    .push_data (parallel_data),
    .pop       (pop),
    .data      (hold_data),
    .full      (hold_full),
    .ready     (parallel_ready)
  );

  assign serial_valid = (state_q == SHIFT);
  assign serial_data  = sh[0];
  assign busy         = (state_q == SHIFT) || hold_full;

endmodule

// File: doc/parallel_to_serial.md
Name: parallel_to_serial

Overview:
- Serializer that feeds serial_to_parallel.
- Accepts width-bit words over a valid/ready handshake and emits them one bit per beat, LSB first.
- Serial side obeys serial_ready backpressure.
- A one-word holding buffer lets back-to-back words stream with no idle beat between them.

Parameters:
- width, 8, word width in bits; legal range 2 or more.

Ports:
- clk  input  1  clock; all state updates on posedge.
- rst  input  1  reset, asynchronous, active-low.
- parallel_valid  input  1  upstream offers parallel_data.
- parallel_ready  output  1  block can accept a word this cycle.
- parallel_data  input  width  word to serialize; bit 0 is sent first.
- serial_valid  output  1  serial_data carries a valid bit.
- serial_data  output  1  current serial bit.
- serial_ready  input  1  downstream consumes the bit this cycle.
- busy  output  1  shifter or holding buffer occupied.

Behaviour:
- Reset (rst low, asynchronous):
  - shifter and holding buffer become empty; bit counter is 0.
  - serial_valid=0, serial_data=0, busy=0, parallel_ready=1.
  - The first edge after rst rises operates normally.
  - Reset mid-word discards the partial word and any held word. No partial word is completed.
- Storage:
  - Shift register sh[width-1:0] with flag sh_full.
  - Holding register hold[width-1:0] with flag hold_full.
  - Bit counter cnt, width $clog2(width+1).
- States: IDLE (sh_full=0) and SHIFT (sh_full=1).
- Handshake:
  - parallel_ready = !hold_full, registered-derived only.
  - It never depends combinationally on serial_ready or parallel_valid.
  - A word is accepted when parallel_valid && parallel_ready at posedge.
- Accept in IDLE:
  - The word loads directly into sh; cnt=0.
  - serial_valid=1 from the next cycle. Latency is 1 cycle from accept to bit 0 on serial_data.
- Accept in SHIFT: the word goes to hold and hold_full=1.
- Outputs:
  - serial_data = sh[0]; serial_valid = sh_full.
  - With serial_valid high and serial_ready low, serial_data and serial_valid hold stable (no drop, no skip).
- Advance: on serial_ready && serial_valid, sh shifts right and cnt increments.
- Last beat (cnt==width-1 && serial_ready):
  - If hold_full: sh<=hold, hold_full<=0, cnt<=0. The next word's bit 0 appears on the very next cycle, with no bubble.
  - Else, if a word is accepted this same cycle: it loads directly into sh, with no bubble.
  - Else: go to IDLE and serial_valid=0.
- Last beat coinciding with an accept while hold_full=1 is impossible, because parallel_ready=0.
- Last beat coinciding with an accept while hold_full=0 and sh busy (covered above): the word goes straight into sh.
- busy = sh_full || hold_full.
- Throughput: sustained 1 bit/cycle with serial_ready tied high; one word per width cycles.
- No combinational path from inputs to outputs except none; all outputs are registered or derived from registers.

Optional Feature:
- Macro: PARALLEL_TO_SERIAL_PARITY_EN.
- Defined:
  - After bit width-1, one extra beat carries even parity (XOR of the word).
  - cnt counts to width, so each word takes width+1 beats.
  - Parity is computed at load time and stored alongside sh.
  - The backpressure rules apply to the parity beat as well.
- Undefined: no parity beat and no parity register; width beats per word.

Decomposition:
- Package parallel_to_serial_pkg holds:
  - function cnt_w(width), returning $clog2(width+1).
  - localparam beats_per_word, which depends on the macro.
  - typedef enum logic {IDLE, SHIFT} p2s_state_t.
- One sub-module, p2s_hold_buf: a single-entry buffer with full flag, push/pop, and registered ready.

Test Plan:
- Reset then single word 8'hA5, serial_ready=1 → bits 1,0,1,0,0,1,0,1 on cycles 1–8 after accept; serial_valid low on cycle 9.
- Back-to-back 8'h0F,8'hF0,8'h3C with parallel_valid held high → 24 consecutive valid beats, no gap; parallel_ready low while hold_full.
- Word 8'h81 with serial_ready low for 5 cycles at bit 3 → serial_data frozen at 0 with serial_valid=1; remaining bits resume in order; total 8 beats.
- Reset (rst=0) asserted mid-word at bit 4 of 8'hFF with a held 8'h55 → serial_valid=0 and busy=0 immediately; after release, 8'h12 serializes cleanly.
- Loopback into serial_to_parallel: 100 random words with random serial_ready → every parallel_data matches in order; the downstream valid count equals 100.
- With PARALLEL_TO_SERIAL_PARITY_EN, word 8'h07 → 9 beats, parity bit 1; word 8'h03 → parity bit 0.
